shiftreg_seq: RTL and testbench

Sequencer for the 16-bit right-shift register. It accepts a shift command (word, shift amount, mode) over a valid/ready handshake and drives the register's load, clear, shift and serial-in controls. It then returns the shifted word over a second valid/ready handshake. It sits between command logic and one shift register instance, and turns the register into a multi-cycle barrel-style shifter.

---
 rtl/shiftreg_seq.sv | 151 +++++++++++++++
 tb/tb_shiftreg_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_seq.sv
// shiftreg_seq: sequencer that turns one 16-bit right-shift register into a
// multi-cycle barrel-style shifter.
//
// Ports:
//   clk, clr_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_amt/in_mode
//                               command handshake (word, amount, mode)
//   flush                       synchronous abort-and-clear request
//   out_valid/out_ready/out_data
//                               result handshake; out_data mirrors sr_q
//   busy                        high in every state except IDLE
//   sr_data_in/sr_ld/sr_clr/sr_sft/sr_s_in
//                               shift register controls (Moore decode)
//   sr_q                        shift register contents
//
// Modes: 00 logical, 01 arithmetic, 10 rotate, 11 logical.
// Optional feature macro: SHIFTREG_SEQ_ROTATE_EN. When it is defined, mode 10
// rotates right. When it is undefined, mode 10 is a logical shift.
//
// The register controls and handshake flags are decoded directly from the
// state register. out_data and sr_s_in follow sr_q combinationally, because
// the register itself holds the value.

module shiftreg_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [WIDTH-1:0] sr_data_in,
  output logic             sr_ld,
  output logic             sr_clr,
  output logic             sr_sft,
  output logic             sr_s_in,
  input  logic [WIDTH-1:0] sr_q
);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_amt;
  logic [AMT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic             w_accept;
  logic             w_s_in;

  // A flush in IDLE wins over a simultaneous command.
  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
  assign out_data = sr_q;

  // Serial-in bit for the current mode.
`ifdef SHIFTREG_SEQ_ROTATE_EN
  always_comb begin
    w_s_in = 1'b0;
    case (r_mode)
      2'b01:   w_s_in = sr_q[WIDTH-1];
      2'b10:   w_s_in = sr_q[0];
      default: w_s_in = 1'b0;
    endcase
  end
`else
  always_comb begin
    w_s_in = 1'b0;
    if (r_mode == 2'b01) w_s_in = sr_q[WIDTH-1];
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= S_CLEAR;
    else        r_state <= w_next;
  end

  // Command capture and shift down-counter.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_data <= '0;
      r_amt  <= '0;
      r_mode <= 2'b00;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_data <= in_data;
        r_amt  <= in_amt;
        r_mode <= in_mode;
      end
      if (r_state == S_LOAD)       r_cnt <= r_amt;
      else if (r_state == S_SHIFT) r_cnt <= r_cnt - AMT_W'(1);
    end
  end

  // Next state and Moore output decode.
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    sr_data_in = '0;
    sr_ld      = 1'b0;
    sr_clr     = 1'b0;
    sr_sft     = 1'b0;
    sr_s_in    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        sr_clr = 1'b1;
        w_next = S_IDLE;
      end
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (w_accept) w_next = S_LOAD;
      end
      S_LOAD: begin
        sr_ld      = 1'b1;
        sr_data_in = r_data;
        w_next     = (r_amt != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        sr_sft  = 1'b1;
        sr_s_in = w_s_in;
        // The counter holds the number of shifts still to be done, including this one.
        if (r_cnt <= AMT_W'(1)) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_CLEAR;
    endcase
    if (flush && (r_state != S_CLEAR)) w_next = S_CLEAR;
  end

endmodule

// File: tb/tb_shiftreg_seq.sv
// tb_shiftreg_seq: directed and randomized bench for shiftreg_seq.
// It drives the sequencer together with a behavioural 16-bit right-shift
// register. Each result is compared with shift arithmetic computed
// independently from the command.

module tb_shiftreg_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned AMT_W = 5;
`ifdef SHIFTREG_SEQ_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic             clk;
  logic             clr_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_mode;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic [WIDTH-1:0] sr_data_in;
  logic             sr_ld;
  logic             sr_clr;
  logic             sr_sft;
  logic             sr_s_in;
  logic [WIDTH-1:0] tb_q;

  int n_tests = 0;
  int n_fail  = 0;

  shiftreg_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_mode    (in_mode),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .sr_data_in (sr_data_in),
    .sr_ld      (sr_ld),
    .sr_clr     (sr_clr),
    .sr_sft     (sr_sft),
    .sr_s_in    (sr_s_in),
    .sr_q       (tb_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shift register that is controlled by the sequencer.
  always_ff @(posedge clk) begin
    if (sr_clr)      tb_q <= '0;
    else if (sr_ld)  tb_q <= sr_data_in;
    else if (sr_sft) tb_q <= {sr_s_in, tb_q[WIDTH-1:1]};
  end

  // Expected result computed directly from the mode and the amount.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int amt,
                                            input logic [1:0] mode);
    logic signed [15:0] s;
    logic [31:0]        dd;
    int                 a;
    if (mode == 2'b01) begin
      a = (amt > 15) ? 15 : amt;
      s = d;
      return 16'(s >>> a);
    end
    if (ROT && mode == 2'b10) begin
      dd = {d, d};
      return 16'(dd >> (amt % 16));
    end
    return (amt > 15) ? 16'h0000 : 16'(d >> amt);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one command and follows it to retirement, checking latency, shifts,
  // serial-in bits, the result and backpressure.
  task automatic run_cmd(input logic [15:0] d, input int amt, input logic [1:0] mode,
                         input int hold, input logic [15:0] exp, input string tag);
    int   w;
    int   cyc;
    int   sft;
    int   bad;
    logic exp_sin;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = 5'(amt);
    in_mode   = mode;
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    chk({tag, "_load"}, {29'd0, sr_ld, in_ready, busy}, 32'b101);
    chk({tag, "_ldata"}, 32'(sr_data_in), 32'(d));
    step();
    cyc = 1;
    sft = 0;
    bad = 0;
    while (!out_valid && cyc < 64) begin
      if (sr_sft) begin
        sft++;
        if (mode == 2'b01)             exp_sin = tb_q[15];
        else if (ROT && mode == 2'b10) exp_sin = tb_q[0];
        else                           exp_sin = 1'b0;
        if (sr_s_in !== exp_sin) bad++;
      end
      step();
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(amt + 1));
    chk({tag, "_nsft"}, 32'(sft), 32'(amt));
    chk({tag, "_sin"}, 32'(bad), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold"}, {30'd0, out_valid, in_ready}, 32'b10);
      chk({tag, "_hdata"}, 32'(out_data), 32'(exp));
    end
    out_ready = 1'b1;
    step();
    chk({tag, "_ret"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [15:0] rd;
    int          ra;
    logic [1:0]  rm;
    clr_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = 2'b00;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_ctl", {26'd0, sr_clr, sr_ld, sr_sft, sr_s_in, in_ready, out_valid}, 32'b100000);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_din", 32'(sr_data_in), 32'd0);
    #10;
    clr_n = 1'b1;
    step();
    chk("post_rst_idle", {30'd0, in_ready, busy}, 32'b10);
    chk("post_rst_q", 32'(tb_q), 32'd0);

    // Directed commands
    run_cmd(16'h8001, 1, 2'b00, 0, 16'h4000, "lsr1");
    run_cmd(16'h8000, 4, 2'b01, 0, 16'hF800, "asr4");
    run_cmd(16'h8000, 20, 2'b01, 0, 16'hFFFF, "asr20");
    run_cmd(16'h1234, 0, 2'b00, 0, 16'h1234, "amt0");
    run_cmd(16'h0001, 1, 2'b10, 0, ROT ? 16'h8000 : 16'h0000, "rot1");
    run_cmd(16'hABCD, 31, 2'b11, 0, 16'h0000, "m11_31");
    run_cmd(16'hF0F0, 4, 2'b00, 3, 16'h0F0F, "bp");

    // Flush during SHIFT
    in_valid = 1'b1; in_data = 16'hFFFF; in_amt = 5'd8; in_mode = 2'b00;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("fl_shift", 32'(sr_sft), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_clr", {29'd0, sr_clr, out_valid, in_ready}, 32'b100);
    step();
    chk("fl_rdy", 32'(in_ready), 32'd1);
    chk("fl_q", 32'(tb_q), 32'd0);
    ra = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) ra++;
      step();
    end
    chk("fl_noval", 32'(ra), 32'd0);

    // Flush beats a simultaneous command in IDLE
    in_valid = 1'b1; in_data = 16'h5555; in_amt = 5'd2; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_idle", {30'd0, sr_clr, sr_ld}, 32'b10);
    step();
    chk("fl_idle_rdy", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-SHIFT
    in_valid = 1'b1; in_data = 16'h7777; in_amt = 5'd10; in_mode = 2'b01;
    step();
    in_valid = 1'b0;
    step();
    step();
    clr_n = 1'b0;
    #1;
    chk("mrst", {28'd0, out_valid, sr_clr, in_ready, sr_sft}, 32'b0100);
    #1;
    clr_n = 1'b1;
    step();
    chk("mrst_q", 32'(tb_q), 32'd0);
    run_cmd(16'h8421, 3, 2'b01, 1, 16'hF084, "after_rst");

    // Randomized commands
    for (int n = 0; n < 25; n++) begin
      rd = 16'($urandom);
      ra = int'($urandom_range(0, 31));
      rm = 2'($urandom_range(0, 3));
      run_cmd(rd, ra, rm, int'($urandom_range(0, 2)), ref_shift(rd, ra, rm), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
